fp16_vec_scale: RTL and testbench

- Downstream consumer of the FP16 inverse-square-root unit, in either its iterative or its pipelined form.
- Holds an N-component FP16 vector and waits for the inverse-sqrt result (done/result/OFUF).
- Multiplies each component by that result through one shared FP16 multiplier, producing a normalised vector.
- Emits one component per transfer on a valid/ready output.

---
 rtl/fp16_vec_scale_pkg.sv | 23 ++
 rtl/fp16_mul_trunc.sv | 62 ++++++
 rtl/fp16_vec_scale.sv | 158 +++++++++++++++
 tb/tb_fp16_vec_scale.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_vec_scale_pkg.sv
// ============================================================================
// fp16_vec_scale_pkg : FP16 field constants and FSM encoding for fp16_vec_scale
// Revision: 1.0
// ============================================================================
`default_nettype none

package fp16_vec_scale_pkg;

  localparam int          EXP_BIAS = 15;
  localparam int          EXP_MAX  = 31;
  localparam logic [15:0] QNAN     = 16'h7E00;
  localparam logic [15:0] POS_INF  = 16'h7C00;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_SCALE = 2'd1,
    S_MUL        = 2'd2,
    S_OUT        = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fp16_mul_trunc.sv
// ============================================================================
// fp16_mul_trunc : combinational FP16 multiply, round toward zero, FTZ inputs
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp16_mul_trunc
  import fp16_vec_scale_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] product,
  output logic [1:0]  ofuf
);

  logic        sign;
  logic        a_max, b_max, a_zero, b_zero;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [21:0] prod;
  logic        norm;
  logic [9:0]  mant;
  logic [6:0]  e_raw;

  always_comb begin
    product = '0;
    ofuf    = '0;
    sign    = a[15] ^ b[15];
    a_max   = (a[14:10] == 5'(EXP_MAX));
    b_max   = (b[14:10] == 5'(EXP_MAX));
    a_zero  = (a[14:10] == 5'd0);
    b_zero  = (b[14:10] == 5'd0);
    a_nan   = a_max && (a[9:0] != 10'd0);
    b_nan   = b_max && (b[9:0] != 10'd0);
    a_inf   = a_max && (a[9:0] == 10'd0);
    b_inf   = b_max && (b[9:0] == 10'd0);
    prod    = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    norm    = prod[21];
    // Truncating casts drop the guard bits: this is the round-toward-zero step.
    mant    = norm ? 10'(prod >> 11) : 10'(prod >> 10);
    // Biased-sum exponent kept offset by EXP_BIAS so the range tests stay unsigned.
    e_raw   = {2'b00, a[14:10]} + {2'b00, b[14:10]} + {6'd0, norm};

    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      product = QNAN;
    end else if (a_inf || b_inf) begin
      product = POS_INF | {sign, 15'd0};
    end else if (a_zero || b_zero) begin
      product = {sign, 15'd0};
    end else if (e_raw < 7'(EXP_BIAS + 1)) begin
      product = {sign, 15'd0};
      ofuf    = 2'b01;
    end else if (e_raw > 7'(EXP_BIAS + EXP_MAX - 1)) begin
      product = POS_INF | {sign, 15'd0};
      ofuf    = 2'b10;
    end else begin
      product = {sign, 5'(e_raw - 7'(EXP_BIAS)), mant};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp16_vec_scale.sv
// ============================================================================
// fp16_vec_scale : scales a held FP16 vector by the inverse-sqrt result,
//                  streaming one component per valid/ready transfer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp16_vec_scale
  import fp16_vec_scale_pkg::*;
#(
  parameter int NUM_COMP = 3,
  parameter int IDX_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vec_load,
  input  logic [16*NUM_COMP-1:0] vec_in,
  output logic                   vec_ready,
  input  logic                   inv_done,
  input  logic [15:0]            inv_result,
  input  logic [1:0]             inv_ofuf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic [1:0]             out_ofuf
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COMP - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e           state_q, state_d;
  logic             inv_done_q;
  logic [15:0]      vec_q [NUM_COMP];
  logic [15:0]      scale_q;
  logic [1:0]       inv_ofuf_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [1:0]       out_ofuf_q, out_ofuf_d;

  logic             inv_edge;
  logic             load_en;
  logic             scale_en;
  logic [IDX_W-1:0] sel_idx;
  logic [15:0]      mul_a;
  logic [15:0]      mul_prod;
  logic [1:0]       mul_ofuf;

  assign inv_edge = inv_done & ~inv_done_q;
  // In OUT the multiplier already works on the next component so a transfer
  // can present it on the following cycle without a bubble.
  assign sel_idx  = (state_q == S_OUT) ? (idx_q + IDX_ONE) : idx_q;

  always_comb begin
    mul_a = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      if (sel_idx == IDX_W'(i)) mul_a = vec_q[i];
    end
  end

  fp16_mul_trunc u_mul (
    .a       (mul_a),
    .b       (scale_q),
    .product (mul_prod),
    .ofuf    (mul_ofuf)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_ofuf_d  = out_ofuf_q;
    load_en     = 1'b0;
    scale_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vec_load) begin
          load_en = 1'b1;
          state_d = S_WAIT_SCALE;
        end
      end
      S_WAIT_SCALE: begin
        if (inv_edge) begin
          scale_en = 1'b1;
          idx_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        out_data_d  = mul_prod;
        out_idx_d   = idx_q;
        out_ofuf_d  = mul_ofuf | inv_ofuf_q;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            idx_d      = idx_q + IDX_ONE;
            out_data_d = mul_prod;
            out_idx_d  = idx_q + IDX_ONE;
            out_ofuf_d = mul_ofuf | inv_ofuf_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      inv_done_q  <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_ofuf_q  <= '0;
    end else begin
      state_q     <= state_d;
      inv_done_q  <= inv_done;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_ofuf_q  <= out_ofuf_d;
    end
  end

  // Operand storage needs no reset: it is always rewritten before being used.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < NUM_COMP; i++) begin
        vec_q[i] <= vec_in[16*i +: 16];
      end
    end
    if (scale_en) begin
      scale_q    <= inv_result;
      inv_ofuf_q <= inv_ofuf;
    end
  end

  assign vec_ready = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_ofuf  = out_ofuf_q;

endmodule

`default_nettype wire

// File: tb/tb_fp16_vec_scale.sv
// ============================================================================
// tb_fp16_vec_scale : scoreboard bench for fp16_vec_scale with a real-valued
//                     FP16 reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp16_vec_scale;

  localparam int NUM_COMP = 3;
  localparam int IDX_W    = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   vec_load;
  logic [16*NUM_COMP-1:0] vec_in;
  logic                   vec_ready;
  logic                   inv_done;
  logic [15:0]            inv_result;
  logic [1:0]             inv_ofuf;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            out_data;
  logic [IDX_W-1:0]       out_idx;
  logic [1:0]             out_ofuf;

  typedef struct packed {
    logic [15:0]      d;
    logic [IDX_W-1:0] i;
    logic [1:0]       f;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rmode   = 0;
  int   stall_cnt = 0;

  fp16_vec_scale #(.NUM_COMP(NUM_COMP), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .vec_load   (vec_load),
    .vec_in     (vec_in),
    .vec_ready  (vec_ready),
    .inv_done   (inv_done),
    .inv_result (inv_result),
    .inv_ofuf   (inv_ofuf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_ofuf   (out_ofuf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real fp_val(input logic [15:0] x);
    real v;
    int  e;
    v = 1.0 + real'(x[9:0]) / 1024.0;
    e = int'(x[14:10]);
    for (int k = e; k > 15; k--) v = v * 2.0;
    for (int k = e; k < 15; k++) v = v / 2.0;
    return v;
  endfunction

  // Returns {flags, result}; value-domain model of the multiply rules.
  function automatic logic [17:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    bit   an, bn, ai, bi, az, bz;
    real  mag;
    int   e, m;
    s  = a[15] ^ b[15];
    an = (a[14:10] == 5'd31) && (a[9:0] != 0);
    bn = (b[14:10] == 5'd31) && (b[9:0] != 0);
    ai = (a[14:10] == 5'd31) && (a[9:0] == 0);
    bi = (b[14:10] == 5'd31) && (b[9:0] == 0);
    az = (a[14:10] == 5'd0);
    bz = (b[14:10] == 5'd0);
    if (an || bn || (ai && bz) || (az && bi)) return {2'b00, 16'h7E00};
    if (ai || bi) return {2'b00, s, 15'h7C00};
    if (az || bz) return {2'b00, s, 15'h0000};
    mag = fp_val(a) * fp_val(b);
    if (mag >= 65536.0) return {2'b10, s, 15'h7C00};
    if (mag < 1.0 / 16384.0) return {2'b01, s, 15'h0000};
    e = 15;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0) begin mag = mag * 2.0; e--; end
    m = $rtoi((mag - 1.0) * 1024.0);
    return {2'b00, s, 5'(e), 10'(m)};
  endfunction

  // Monitor: compare every presented beat against the queue head, pop on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        chk("vec_ready_low_in_out", {31'd0, vec_ready}, 32'd0);
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got data=0x%0h idx=%0d expected none at %0t",
                   out_data, out_idx, $time);
        end else begin
          chk("out_beat", {12'd0, out_data, out_idx, out_ofuf}, {12'd0, q[0]});
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = stall idx1 for 3 cycles.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: out_ready = 1'($urandom % 2);
        2: begin
          if (out_valid && out_idx == 2'd1 && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 50 && !vec_ready; k++) tick();
    if (!vec_ready) chk("vec_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 100 && !(q.size() == 0 && vec_ready); k++) tick();
    if (!(q.size() == 0 && vec_ready)) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  function automatic logic [15:0] rnd_fp();
    logic [15:0] sp[8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                           16'h7E00, 16'h0001, 16'h7BFF, 16'h0400};
    if ($urandom % 8 == 0) return sp[$urandom % 8];
    return 16'($urandom);
  endfunction

  // mode: 0 normal, 1 latency check, 2 reset after idx0, 3 inv_done pre-held,
  //       4 extra vec_load during OUT
  task automatic run_vec(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                         input logic [15:0] sc, input logic [1:0] of, input int mode);
    logic [15:0] c[3];
    logic [17:0] r;
    int          k;
    c[0] = c0; c[1] = c1; c[2] = c2;
    wait_ready();
    if (mode == 3) begin
      inv_done = 1'b1;
      tick();
    end
    vec_in   = {c2, c1, c0};
    vec_load = 1'b1;
    tick();
    vec_load   = 1'b0;
    vec_in     = {16'($urandom), 16'($urandom), 16'($urandom)};
    inv_result = sc;
    inv_ofuf   = of;
    if (mode == 3) begin
      for (k = 0; k < 4; k++) begin
        tick();
        chk("held_done_no_valid", {31'd0, out_valid}, 32'd0);
        chk("held_done_vec_ready", {31'd0, vec_ready}, 32'd0);
      end
    end
    inv_done = 1'b0;
    tick();
    inv_done = 1'b1;
    for (int j = 0; j < NUM_COMP; j++) begin
      r = ref_mul(c[j], sc);
      q.push_back('{d: r[15:0], i: IDX_W'(j), f: r[17:16] | of});
    end
    tick();
    inv_done   = 1'b0;
    inv_result = 16'($urandom);
    inv_ofuf   = 2'($urandom);
    if (mode == 1) begin
      chk("lat_mul_no_valid", {31'd0, out_valid}, 32'd0);
      for (k = 2; k <= NUM_COMP + 2; k++) begin
        tick();
        chk("lat_valid", {31'd0, out_valid}, {31'd0, (k <= NUM_COMP + 1)});
        chk("lat_vec_ready", {31'd0, vec_ready}, {31'd0, (k == NUM_COMP + 2)});
      end
    end
    if (mode == 4) begin
      for (k = 0; k < 20 && !out_valid; k++) tick();
      chk("inject_in_out", {31'd0, out_valid}, 32'd1);
      vec_in   = {16'h3C00, 16'h3C00, 16'h3C00};
      vec_load = 1'b1;
      tick();
      vec_load = 1'b0;
    end
    if (mode == 2) begin
      for (k = 0; k < 20 && !(out_valid && out_idx == 2'd1); k++) tick();
      chk("abort_at_idx1", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      q.delete();
      tick();
      reset = 1'b0;
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_vec_ready", {31'd0, vec_ready}, 32'd1);
      repeat (6) tick();
      chk("abort_still_idle", {31'd0, vec_ready}, 32'd1);
      return;
    end
    wait_drain();
  endtask

  initial begin
    reset = 1'b1; vec_load = 1'b0; vec_in = '0;
    inv_done = 1'b0; inv_result = '0; inv_ofuf = '0;
    repeat (3) tick();
    chk("rst_vec_ready", {31'd0, vec_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_idx", {30'd0, out_idx}, 32'd0);
    chk("rst_out_ofuf", {30'd0, out_ofuf}, 32'd0);
    reset = 1'b0;
    tick();

    rmode = 0;
    run_vec(16'h4000, 16'hC000, 16'h4200, 16'h3800, 2'b00, 1);
    run_vec(16'h7800, 16'h3C00, 16'h0400, 16'h4000, 2'b00, 0);
    run_vec(16'h0400, 16'hBC00, 16'h3C00, 16'h3800, 2'b00, 0);
    run_vec(16'h3C01, 16'hBC01, 16'h7BFF, 16'h3C01, 2'b00, 0);
    run_vec(16'h7E00, 16'h7C00, 16'h0000, 16'h3C00, 2'b00, 0);
    run_vec(16'h7C00, 16'h3C00, 16'h8000, 16'h0000, 2'b00, 0);

    rmode = 2; stall_cnt = 0;
    run_vec(16'h3C00, 16'h4400, 16'hC200, 16'h3A00, 2'b10, 0);
    chk("stall_applied", stall_cnt, 32'd3);

    rmode = 0;
    run_vec(16'h4000, 16'h4400, 16'h4800, 16'h3400, 2'b00, 3);
    rmode = 2; stall_cnt = 0;
    run_vec(16'h4100, 16'h4500, 16'h4900, 16'h3800, 2'b01, 4);

    rmode = 0;
    run_vec(16'h4000, 16'h4200, 16'h4400, 16'h3C00, 2'b00, 2);
    run_vec(16'h4600, 16'hC600, 16'h3000, 16'h3800, 2'b00, 0);

    rmode = 1;
    for (int t = 0; t < 30; t++) begin
      run_vec(rnd_fp(), rnd_fp(), rnd_fp(),
              {1'($urandom), 5'(8 + $urandom % 16), 10'($urandom)},
              ($urandom % 4 == 0) ? 2'($urandom) : 2'b00, 0);
      if (t % 5 == 0) run_vec(rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), 2'b00, 0);
    end

    repeat (3) tick();
    chk("final_queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
